// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
//   Command-driven sequencer for a W-bit universal shift register. A command is
//   accepted with a valid/ready handshake. The sequencer parallel-loads the
//   command word into the register and then issues cmd_count logical or
//   circular shift cycles in the requested direction. A one-cycle done pulse
//   marks completion.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   cmd_valid/ready   : command handshake (ready only in IDLE)
//   cmd_data          : word to parallel-load
//   cmd_dir           : 0 = left, 1 = right
//   cmd_circ          : 0 = logical shift, 1 = circular rotate
//   cmd_fill          : serial fill bit for logical shifts
//   cmd_count         : number of shift cycles (0 = load only)
//   pause             : stalls the shift phase
//   enb/dir/s_in/mode/d : shift register controls
//   busy              : high in every state except IDLE
//   done              : one-cycle completion pulse
// -----------------------------------------------------------------------------
module shift_seq_ctrl #(
    parameter int W     = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [W-1:0]     cmd_data,
    input  logic             cmd_dir,
    input  logic             cmd_circ,
    input  logic             cmd_fill,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             pause,
    output logic             enb,
    output logic             dir,
    output logic             s_in,
    output logic [1:0]       mode,
    output logic [W-1:0]     d,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_SHIFT  = 2'b00;
    localparam logic [1:0] MODE_ROTATE = 2'b01;
    localparam logic [1:0] MODE_LOAD   = 2'b10;

    state_t             state_q, state_d;
    logic [W-1:0]       data_q, data_d;
    logic               dir_q, dir_d;
    logic               circ_q, circ_d;
    logic               fill_q, fill_d;
    logic [CNT_W-1:0]   rem_q, rem_d;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values computed before the edge regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            dir_q   <= 1'b0;
            circ_q  <= 1'b0;
            fill_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            circ_q  <= circ_d;
            fill_q  <= fill_d;
            rem_q   <= rem_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        dir_d     = dir_q;
        circ_d    = circ_q;
        fill_d    = fill_q;
        rem_d     = rem_q;
        cmd_ready = 1'b0;
        enb       = 1'b0;
        mode      = MODE_SHIFT;
        done      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Ready is forced low while reset is held.
                cmd_ready = ~rst;
                if (cmd_valid) begin
                    data_d  = cmd_data;
                    dir_d   = cmd_dir;
                    circ_d  = cmd_circ;
                    fill_d  = cmd_fill;
                    // The count goes straight into the down-counter, so the
                    // remaining count already equals the captured count in LOAD.
                    rem_d   = cmd_count;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                enb     = 1'b1;
                mode    = MODE_LOAD;
                state_d = (rem_q != '0) ? S_SHIFT : S_DONE;
            end
            S_SHIFT: begin
                mode = circ_q ? MODE_ROTATE : MODE_SHIFT;
                if (!pause) begin
                    enb   = 1'b1;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Data-path outputs come from captured fields only; the fill bit is
    // suppressed for rotates so the register never sees a stray serial input.
    assign d    = data_q;
    assign dir  = dir_q;
    assign s_in = fill_q & ~circ_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_seq_ctrl
//   Scoreboard bench for shift_seq_ctrl. The stimulus process pushes the
//   expected enabled cycles and the expected completion of each command into
//   queues; a monitor on the falling edge pops and compares whenever the DUT
//   asserts enb or done. A behavioural 4-bit universal shift register is driven
//   by the DUT outputs to observe the downstream register contents.
// -----------------------------------------------------------------------------
module tb_shift_seq_ctrl;

    localparam int W     = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [W-1:0]     cmd_data;
    logic             cmd_dir;
    logic             cmd_circ;
    logic             cmd_fill;
    logic [CNT_W-1:0] cmd_count;
    logic             pause;
    logic             enb;
    logic             dir;
    logic             s_in;
    logic [1:0]       mode;
    logic [W-1:0]     d;
    logic             busy;
    logic             done;

    shift_seq_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_dir   (cmd_dir),
        .cmd_circ  (cmd_circ),
        .cmd_fill  (cmd_fill),
        .cmd_count (cmd_count),
        .pause     (pause),
        .enb       (enb),
        .dir       (dir),
        .s_in      (s_in),
        .mode      (mode),
        .d         (d),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   mode;
        logic         dir;
        logic         s_in;
        logic [W-1:0] d;
        logic [W-1:0] pre;    // downstream register value before this edge
        bit           first;  // the LOAD cycle of a command
    } enb_exp_t;

    typedef struct {
        int           acc;    // cycle index of the accept edge
        int           lat;    // cycles from accept to the done cycle
        logic [W-1:0] fin;    // downstream register value when done is seen
    } done_exp_t;

    enb_exp_t  exp_enb[$];
    done_exp_t exp_done[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int ready_chk = -1;
    logic [W-1:0] dreg = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream universal shift register driven by the DUT controls.
    always @(posedge clk) begin
        if (enb) begin
            case (mode)
                2'b10:   dreg <= d;
                2'b00:   dreg <= dir ? {s_in, dreg[W-1:1]} : {dreg[W-2:0], s_in};
                2'b01:   dreg <= dir ? {dreg[0], dreg[W-1:1]} : {dreg[W-2:0], dreg[W-1]};
                default: dreg <= dreg;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event not expected (cycle %0d)", name, cyc);
    endtask

    // Monitor: compares whenever the DUT presents enb or done.
    always @(negedge clk) begin
        if (!rst) begin
            if (enb) begin
                if (exp_enb.size() == 0) begin
                    flag("enb_unexpected");
                end else begin
                    enb_exp_t e;
                    e = exp_enb.pop_front();
                    check("enb_mode", 32'(mode), 32'(e.mode));
                    check("enb_dir",  32'(dir),  32'(e.dir));
                    check("enb_s_in", 32'(s_in), 32'(e.s_in));
                    check("enb_d",    32'(d),    32'(e.d));
                    if (e.first) begin
                        check("load_ready_low", 32'(cmd_ready), 32'd0);
                        check("load_busy",      32'(busy),      32'd1);
                    end else begin
                        check("shift_reg_pre", 32'(dreg), 32'(e.pre));
                    end
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    flag("done_unexpected");
                end else begin
                    done_exp_t x;
                    x = exp_done.pop_front();
                    check("done_latency", 32'(cyc - x.acc), 32'(x.lat));
                    check("done_reg",     32'(dreg),        32'(x.fin));
                    check("done_enb",     32'(enb),         32'd0);
                    check("done_mode",    32'(mode),        32'd0);
                    ready_chk = cyc + 1;
                end
            end
            if (cyc == ready_chk) begin
                check("ready_after_done", 32'(cmd_ready), 32'd1);
                check("idle_busy",        32'(busy),      32'd0);
            end
        end
    end

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] r, input logic dr,
                                               input logic circ, input logic fill);
        logic b;
        if (dr) begin
            b = circ ? r[0] : fill;
            return {b, r[W-1:1]};
        end
        b = circ ? r[W-1] : fill;
        return {r[W-2:0], b};
    endfunction

    // Issue one command and push its expected behaviour. fin is the
    // hand-computed final register value; extra is the number of paused cycles.
    task automatic send(input logic [W-1:0] data, input logic dr, input logic circ,
                        input logic fill, input int count, input logic [W-1:0] fin,
                        input int extra, output int acc);
        int n;
        logic [W-1:0] r;
        enb_exp_t e;
        done_exp_t x;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_data  = data;
        cmd_dir   = dr;
        cmd_circ  = circ;
        cmd_fill  = fill;
        cmd_count = CNT_W'(count);
        @(posedge clk);
        #1;
        acc = cyc;
        // Scramble the command bus; the operation in progress must not care.
        cmd_valid = 1'b0;
        cmd_data  = ~data;
        cmd_dir   = ~dr;
        cmd_circ  = ~circ;
        cmd_fill  = ~fill;
        cmd_count = ~CNT_W'(count);

        e.mode  = 2'b10;
        e.dir   = dr;
        e.s_in  = fill & ~circ;
        e.d     = data;
        e.pre   = '0;
        e.first = 1'b1;
        exp_enb.push_back(e);
        r = data;
        for (int i = 0; i < count; i++) begin
            e.mode  = circ ? 2'b01 : 2'b00;
            e.pre   = r;
            e.first = 1'b0;
            exp_enb.push_back(e);
            r = ref_shift(r, dr, circ, fill);
        end
        x.acc = acc;
        x.lat = count + 1 + extra;
        x.fin = fin;
        exp_done.push_back(x);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_done.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("drain_timeout", 32'(n < 300), 32'd1);
    endtask

    initial begin
        int a1, a2;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        cmd_dir   = 1'b0;
        cmd_circ  = 1'b0;
        cmd_fill  = 1'b0;
        cmd_count = '0;
        pause     = 1'b0;

        // Reset state.
        #1;
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_enb",   32'(enb),       32'd0);
        check("rst_mode",  32'(mode),      32'd0);
        check("rst_d",     32'(d),         32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        #11 rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Logical left, fill 1: 1010 -> 0101 -> 1011 -> 0111 -> 1111.
        send(4'b1010, 1'b0, 1'b0, 1'b1, 4, 4'b1111, 0, a1);
        drain();

        // Circular right: 0001 -> 1000 -> 0100 -> 0010 -> 0001.
        send(4'b0001, 1'b1, 1'b1, 1'b0, 4, 4'b0001, 0, a1);
        drain();

        // Load only.
        send(4'b0110, 1'b0, 1'b0, 1'b0, 0, 4'b0110, 0, a1);
        drain();

        // Pause for two cycles after the first shift: 1100 right logical.
        send(4'b1100, 1'b1, 1'b0, 1'b0, 3, 4'b0001, 2, a1);
        repeat (2) @(posedge clk);
        #1 pause = 1'b1;
        #1 check("pause_enb_0", 32'(enb), 32'd0);
        @(posedge clk);
        #1 check("pause_enb_1", 32'(enb), 32'd0);
        @(posedge clk);
        #1 pause = 1'b0;
        drain();

        // Command pulsed while busy is ignored: 0011 left logical fill 0.
        send(4'b0011, 1'b0, 1'b0, 1'b0, 3, 4'b1000, 0, a1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_data  = 4'b1111;
        cmd_count = CNT_W'(1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check("ignored_d", 32'(d), 32'b0011);
        drain();

        // Back-to-back: second accept at the first ready edge.
        send(4'b0101, 1'b1, 1'b1, 1'b0, 2, 4'b0101, 0, a1);
        send(4'b0111, 1'b0, 1'b0, 1'b0, 1, 4'b1110, 0, a2);
        check("b2b_gap", 32'(a2 - a1), 32'd5);
        drain();

        // Asynchronous reset mid-SHIFT.
        send(4'b1001, 1'b0, 1'b1, 1'b0, 7, 4'b1001, 0, a1);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        exp_enb.delete();
        exp_done.delete();
        ready_chk = -1;
        check("midrst_enb",   32'(enb),       32'd0);
        check("midrst_mode",  32'(mode),      32'd0);
        check("midrst_dir",   32'(dir),       32'd0);
        check("midrst_s_in",  32'(s_in),      32'd0);
        check("midrst_d",     32'(d),         32'd0);
        check("midrst_busy",  32'(busy),      32'd0);
        check("midrst_done",  32'(done),      32'd0);
        check("midrst_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready_after", 32'(cmd_ready), 32'd1);
        check("midrst_busy_after",  32'(busy),      32'd0);
        repeat (12) @(posedge clk);

        #1;
        check("enb_queue_empty",  32'(exp_enb.size()),  32'd0);
        check("done_queue_empty", 32'(exp_done.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Command-driven sequencer that sits directly upstream of the 4-bit universal shift register and generates its control inputs (`enb`, `dir`, `s_in`, `mode`, `d`). It accepts one command per valid/ready handshake, parallel-loads the command word into the register, then issues a programmed number of logical or circular shift cycles in the requested direction. It signals completion with a one-cycle `done` pulse, so software or a higher-level FSM can queue shift operations without hand-timing the register controls.

## Interface
Parameters:
- `W`, 4, data width; must match the shift register width.
- `CNT_W`, 3, width of the shift-count field; maximum count is 2^CNT_W-1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_data`  in  W  word to parallel-load.
- `cmd_dir`  in  1  0 = left, 1 = right.
- `cmd_circ`  in  1  0 = logical shift (mode 00), 1 = circular rotate (mode 01).
- `cmd_fill`  in  1  serial fill bit driven on `s_in` during logical shifts.
- `cmd_count`  in  CNT_W  number of shift cycles; 0 = load only.
- `pause`  in  1  stall the shift phase.
- `enb`  out  1  shift register enable.
- `dir`  out  1  shift register direction.
- `s_in`  out  1  shift register serial input.
- `mode`  out  2  shift register mode: 00 shift, 01 rotate, 10 load; 11 is never driven.
- `d`  out  W  shift register parallel data.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - `cmd_ready`=1. When `cmd_valid` is high at an edge, capture all `cmd_*` fields into internal registers and go to LOAD.
  - `enb`=0, `mode`=00.
- LOAD: `enb`=1, `mode`=10, `d`=captured data.
  - Next state is SHIFT if count≠0, else DONE.
  - The remaining-count register is loaded with the captured count.
- SHIFT: `mode`=01 if circ, else 00. `dir`=captured dir. `s_in`=captured fill; `s_in`=0 when circ.
  - If `pause`=0: `enb`=1 and remaining decrements each edge. When remaining is 1 at an edge, go to DONE.
  - If `pause`=1: `enb`=0, remaining holds, state holds.
- DONE: `enb`=0, `mode`=00, `done`=1. Unconditionally returns to IDLE.
- `d` holds the captured word from LOAD until the next capture.
- `dir` and `s_in` hold their captured values outside SHIFT.
- All outputs are decoded from registered state and captured fields only. Nothing depends combinationally on `cmd_*` or `pause`, except `enb` in SHIFT, which is gated by `pause`.
- `cmd_valid` outside IDLE is ignored; no command is buffered.
- `cmd_*` changes after capture have no effect on the operation in progress.
- Reset (asynchronous, any state, including mid-SHIFT):
  - State goes to IDLE and the captured command is discarded; no `done` is issued.
  - Outputs: `enb`=0, `mode`=00, `dir`=0, `s_in`=0, `d`=0, `busy`=0, `done`=0.
  - `cmd_ready`=0 while `rst` is high and 1 from the first cycle after release.

## Timing
- Command accepted at edge E0.
- Cycle after E0: LOAD outputs are visible; the register loads at E1.
- Shifts occur at edges E2..E(count+1), assuming no pause.
- `done` is high in the cycle after E(count+1). `cmd_ready` returns in the cycle after E(count+2).
- `cmd_ready` is low for exactly count+2 cycles; with count=0 it is low for 2 cycles.
- Each paused SHIFT cycle extends all later events by one cycle.
- `pause` is ignored in LOAD and DONE.
- Back-to-back commands: the next accept can occur at the first edge with `cmd_ready`=1. Peak throughput is one command per count+3 cycles.

## Test plan
- Reset: assert `rst` asynchronously between edges during SHIFT, then release.
  - Required: outputs go to reset values immediately, `busy`=0, no `done` pulse, and `cmd_ready`=1 the cycle after release.
- Logical left: data=1010, count=4, dir=0, circ=0, fill=1.
  - Required: one LOAD cycle with `mode`=10, `d`=1010; then 4 cycles of `enb`=1, `mode`=00, `s_in`=1.
  - Required: `done` in cycle 6 after accept; downstream register ends at 1111.
- Circular right: data=0001, count=4, dir=1, circ=1.
  - Required: `mode`=01 for 4 enabled cycles and `s_in`=0; downstream register passes 1000, 0100, 0010 and ends at 0001.
- Load only: count=0, data=0110.
  - Required: LOAD then DONE, `cmd_ready` low for exactly 2 cycles; no cycle with `mode`=00 and `enb`=1.
- Pause: count=3, `pause` high for 2 cycles after the first shift.
  - Required: `enb`=0 during the pause, exactly 3 enabled shift cycles in total, `done` delayed by 2 cycles.
- Ignored command: pulse `cmd_valid` with data=1111 while busy.
  - Required: not captured, `d` unchanged, and exactly one `done` for the original command.
